// File: rtl/sdram_dev_model.sv
// Device-side SDR SDRAM responder: decodes commands, tracks open rows per bank, stores
// data in a reduced array, returns reads after CAS latency and flags controller protocol violations.
module sdram_dev_model #(
  parameter int ROW_W        = 13,
  parameter int COL_W        = 9,
  parameter int MEM_ROW_BITS = 4,
  parameter int MEM_COL_BITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sdram_cke,
  input  logic             sdram_csn,
  input  logic             sdram_rasn,
  input  logic             sdram_casn,
  input  logic             sdram_wen,
  input  logic [1:0]       sdram_ba,
  input  logic [ROW_W-1:0] sdram_addr,
  input  logic [15:0]      sdram_data_i,
  output logic [15:0]      sdram_data_o,
  output logic             sdram_data_oe,
  output logic             mode_set,
  output logic             prot_err,
  output logic [15:0]      ref_cnt
);
  localparam int IDX_W = 2 + MEM_ROW_BITS + MEM_COL_BITS;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  logic [15:0]      mem [DEPTH];
  logic [3:0]       bank_open;
  logic [ROW_W-1:0] bank_row [4];
  logic [1:0]       cl;
  logic             pv [1:3];
  logic [15:0]      pd [1:3];

  logic             cmd_vld, cur_open, a10, pipe_any, lmr_ok;
  logic             is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
  logic             viol;
  logic [2:0]       cmd;
  logic [COL_W-1:0] col;
  logic [IDX_W-1:0] idx;
  logic [15:0]      rd_dat;
  logic             unused_bits;

  assign cmd_vld  = sdram_cke & ~sdram_csn;
  assign cmd      = {sdram_rasn, sdram_casn, sdram_wen};
  assign is_act   = cmd_vld && (cmd == CMD_ACT);
  assign is_rd    = cmd_vld && (cmd == CMD_RD);
  assign is_wr    = cmd_vld && (cmd == CMD_WR);
  assign is_pre   = cmd_vld && (cmd == CMD_PRE);
  assign is_ref   = cmd_vld && (cmd == CMD_REF);
  assign is_lmr   = cmd_vld && (cmd == CMD_LMR);
  assign cur_open = bank_open[sdram_ba];
  assign a10      = sdram_addr[10];
  assign col      = sdram_addr[COL_W-1:0];
  assign idx      = {sdram_ba, bank_row[sdram_ba][MEM_ROW_BITS-1:0], col[MEM_COL_BITS-1:0]};
  assign rd_dat   = mem[idx];
  assign pipe_any = pv[1] | pv[2] | pv[3];
  assign lmr_ok   = (sdram_addr[6:4] == 3'd2 || sdram_addr[6:4] == 3'd3) &&
                    (sdram_addr[2:0] == 3'd0) && (bank_open == 4'd0);

  assign unused_bits = ^{sdram_addr, bank_row[0], bank_row[1], bank_row[2], bank_row[3], col};

  always_comb begin
    viol = 1'b0;
    if (is_act && cur_open) viol = 1'b1;
    if ((is_rd || is_wr) && !cur_open) viol = 1'b1;
    if (is_ref && (bank_open != 4'd0)) viol = 1'b1;
    if (is_lmr && (!lmr_ok || pipe_any)) viol = 1'b1;
  end

  // Array is deliberately left out of reset so contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (is_wr && cur_open) mem[idx] <= sdram_data_i;
  end

  assign sdram_data_o  = pd[1];
  assign sdram_data_oe = pv[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_open <= 4'd0;
      for (int b = 0; b < 4; b++) bank_row[b] <= '0;
      for (int s = 1; s <= 3; s++) begin
        pv[s] <= 1'b0;
        pd[s] <= 16'd0;
      end
      cl       <= 2'd3;
      mode_set <= 1'b0;
      prot_err <= 1'b0;
      ref_cnt  <= 16'd0;
    end else begin
      pv[1] <= pv[2];
      pd[1] <= pd[2];
      pv[2] <= pv[3];
      pd[2] <= pd[3];
      pv[3] <= 1'b0;
      pd[3] <= 16'd0;
      // Insert so the word lands in the output stage exactly CL-1 edges later.
      if (is_rd && cur_open) begin
        if (cl == 2'd2) begin
          pv[2] <= 1'b1;
          pd[2] <= rd_dat;
        end else begin
          pv[3] <= 1'b1;
          pd[3] <= rd_dat;
        end
      end

      prot_err <= prot_err | viol;

      if (is_act) begin
        bank_open[sdram_ba] <= 1'b1;
        bank_row[sdram_ba]  <= sdram_addr;
      end
      if (is_pre) begin
        if (a10) bank_open <= 4'd0;
        else     bank_open[sdram_ba] <= 1'b0;
      end
      if ((is_rd || is_wr) && cur_open && a10) bank_open[sdram_ba] <= 1'b0;
      if (is_ref && ref_cnt != 16'hFFFF) ref_cnt <= ref_cnt + 16'd1;
      if (is_lmr && lmr_ok) begin
        cl       <= sdram_addr[5:4];
        mode_set <= 1'b1;
      end
    end
  end
endmodule
